// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC streaming controller.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int UNDER_HOLD = 0;
  localparam int UNDER_MID  = 1;

  // True when phase lies in the DIV/2-wide write window that opens at wrt_ph, wrapping modulo div.
  function automatic logic in_wrt_window(input int phase, input int wrt_ph, input int div);
    int rel;
    rel = (phase - wrt_ph + div) % div;
    return (rel < (div / 2));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dac_stream_ctrl.sv
// Streams FIFO-buffered samples to a parallel DAC, generating dac_clk/dac_wrt by dividing clk.
module dac_stream_ctrl
  import dac_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int DIV        = 4,
  parameter int WRT_PH     = 1,
  parameter int DEPTH      = 4,
  parameter int OFFSET_BIN = 0,
  parameter int UNDER_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dac_wrt,
  output logic              dac_clk,
  output logic [DATA_W-1:0] dac_data,
  output logic              running,
  output logic              underflow,
  output logic [15:0]       under_cnt
);

  localparam int          PW       = $clog2(DIV);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PH  = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF_PH  = PW'(DIV / 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  state_t                   state;
  state_t                   state_nx;
  logic [PW-1:0]            phase;
  logic [PW-1:0]            phase_nx;
  logic signed [DATA_W-1:0] cur;
  logic signed [DATA_W-1:0] cur_nx;
  logic [DATA_W-1:0]        fifo_dout;
  logic [AW:0]              fifo_count;
  logic                     fifo_empty;
  logic                     at_last;
  logic                     pop_slot;
  logic                     starved;

  function automatic logic [DATA_W-1:0] fmt_out(input logic signed [DATA_W-1:0] s);
    if (OFFSET_BIN != 0) return {~s[DATA_W-1], s[DATA_W-2:0]};
    return s;
  endfunction

  assign s_ready = rst_n && (fifo_count != FULL_CNT);

  sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (s_valid && s_ready),
    .din  (s_data),
    .pop  (pop_slot),
    .dout (fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = STOP;
      STOP: begin
        if (en)           state_nx = RUN;
        else if (at_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign at_last = (phase == LAST_PH);
  // A period that ends in IDLE has no phase 0 to show a new sample, so nothing is consumed.
  assign pop_slot = (state != IDLE) && at_last && (state_nx != IDLE);
  assign starved  = pop_slot && fifo_empty;

  always_comb begin
    phase_nx = '0;
    if (state != IDLE && state_nx != IDLE && !at_last) phase_nx = phase + PW'(1);
  end

  always_comb begin
    cur_nx = cur;
    if (pop_slot) begin
      if (!fifo_empty)                   cur_nx = fifo_dout;
      else if (UNDER_MODE == UNDER_MID)  cur_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      cur       <= '0;
      running   <= 1'b0;
      dac_clk   <= 1'b0;
      dac_wrt   <= 1'b0;
      dac_data  <= '0;
      underflow <= 1'b0;
      under_cnt <= '0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      cur       <= cur_nx;
      running   <= (state_nx != IDLE);
      // Outputs are computed from the next phase so each register lines up with the phase it reports.
      dac_clk   <= (state_nx != IDLE) && (phase_nx >= HALF_PH);
      dac_wrt   <= (state_nx != IDLE) && in_wrt_window(int'(phase_nx), WRT_PH, DIV);
      dac_data  <= (state_nx == IDLE) ? '0 : fmt_out(cur_nx);
      underflow <= starved;
      if (starved && under_cnt != 16'hFFFF) under_cnt <= under_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Scoreboard bench: three controller variants (hold, midscale underflow, offset binary) share one stimulus.
module tb_dac_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        s_valid;
  logic [13:0] s_data;

  logic [2:0]  rdy, wrt, dclk, run, uf;
  logic [13:0] dd [3];
  logic [15:0] uc [3];

  int checks = 0;
  int errors = 0;
  int extra [3] = '{0, 0, 0};
  int uf_cnt [3] = '{0, 0, 0};
  logic [2:0] pw = '0;

  logic [13:0] q0 [$];
  logic [13:0] q1 [$];
  logic [13:0] q2 [$];
  logic [13:0] l0 = '0, l1 = '0, l2 = '0;

  always #5 clk = ~clk;

  dac_stream_ctrl #(.DATA_W(14), .DIV(4), .WRT_PH(1), .DEPTH(4), .OFFSET_BIN(0), .UNDER_MODE(0)) u_hold (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
    .dac_wrt(wrt[0]), .dac_clk(dclk[0]), .dac_data(dd[0]), .running(run[0]),
    .underflow(uf[0]), .under_cnt(uc[0]));

  dac_stream_ctrl #(.DATA_W(14), .DIV(4), .WRT_PH(1), .DEPTH(4), .OFFSET_BIN(0), .UNDER_MODE(1)) u_mid (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
    .dac_wrt(wrt[1]), .dac_clk(dclk[1]), .dac_data(dd[1]), .running(run[1]),
    .underflow(uf[1]), .under_cnt(uc[1]));

  dac_stream_ctrl #(.DATA_W(14), .DIV(4), .WRT_PH(1), .DEPTH(4), .OFFSET_BIN(1), .UNDER_MODE(0)) u_ofs (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[2]),
    .dac_wrt(wrt[2]), .dac_clk(dclk[2]), .dac_data(dd[2]), .running(run[2]),
    .underflow(uf[2]), .under_cnt(uc[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected value for each sample period, per variant.
  task automatic exp_sample(input logic [13:0] d);
    l0 = d; l1 = d; l2 = d;
    q0.push_back(d); q1.push_back(d); q2.push_back(d ^ 14'h2000);
  endtask

  task automatic exp_under();
    l1 = '0;
    q0.push_back(l0); q1.push_back(l1); q2.push_back(l2 ^ 14'h2000);
  endtask

  task automatic exp_hold();
    q0.push_back(l0); q1.push_back(l1); q2.push_back(l2 ^ 14'h2000);
  endtask

  // Each dac_wrt rise marks a new period; its data word must match the scoreboard head.
  always @(negedge clk) begin
    if (wrt[0] && !pw[0]) begin
      if (q0.size() == 0) extra[0] <= extra[0] + 1;
      else check_eq("data_hold", 32'(dd[0]), 32'(q0.pop_front()));
    end
    if (wrt[1] && !pw[1]) begin
      if (q1.size() == 0) extra[1] <= extra[1] + 1;
      else check_eq("data_mid", 32'(dd[1]), 32'(q1.pop_front()));
    end
    if (wrt[2] && !pw[2]) begin
      if (q2.size() == 0) extra[2] <= extra[2] + 1;
      else check_eq("data_ofs", 32'(dd[2]), 32'(q2.pop_front()));
    end
    pw <= wrt;
    if (rst_n) for (int i = 0; i < 3; i++) uf_cnt[i] <= uf_cnt[i] + int'(uf[i]);
  end

  task automatic push_sample(input logic [13:0] d);
    @(negedge clk);
    check_eq("ready_push", 32'(rdy[0]), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    exp_sample(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // k = 0 is the first RUN cycle (phase 0); en drops for good at stop_k and for one cycle at blip_k.
  task automatic run_seq(input int stop_k, input int blip_k, input int push_a, input int push_b);
    logic active;
    int   ph;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k <= stop_k + 3; k++) begin
      @(negedge clk);
      active = (k < stop_k + 3);
      ph = k % 4;
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("dac_clk%0d_k%0d", i, k), 32'(dclk[i]), 32'(active && ph >= 2));
        check_eq($sformatf("dac_wrt%0d_k%0d", i, k), 32'(wrt[i]), 32'(active && (ph == 1 || ph == 2)));
        check_eq($sformatf("running%0d_k%0d", i, k), 32'(run[i]), 32'(active));
        if (!active) begin
          check_eq($sformatf("idle_data%0d", i), 32'(dd[i]), 32'd0);
          check_eq($sformatf("idle_uf%0d", i), 32'(uf[i]), 32'd0);
        end
      end
      if (push_a >= 0) begin
        if (k == 3) check_eq("ready_full_k3", 32'(rdy[0]), 32'd0);
        if (k == push_a || k == push_b) check_eq($sformatf("ready_k%0d", k), 32'(rdy[0]), 32'd1);
        if (k == push_b + 1) check_eq("ready_refull", 32'(rdy[0]), 32'd0);
      end
      en      = !(k == blip_k || k >= stop_k);
      s_valid = (k == push_a || k == push_b);
      if (s_valid) begin
        s_data = (k == push_a) ? 14'h0200 : 14'h0201;
        exp_sample(s_data);
      end
    end
    en      = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic check_under(input int n);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("uf_pulses%0d", i), 32'(uf_cnt[i]), 32'(n));
      check_eq($sformatf("under_cnt%0d", i), 32'(uc[i]), 32'(n));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    s_valid = 1'b1;
    s_data  = 14'h0155;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_data",  32'(dd[i]),   32'd0);
      check_eq("rst_clk",   32'(dclk[i]), 32'd0);
      check_eq("rst_wrt",   32'(wrt[i]),  32'd0);
      check_eq("rst_run",   32'(run[i]),  32'd0);
      check_eq("rst_uf",    32'(uf[i]),   32'd0);
      check_eq("rst_ucnt",  32'(uc[i]),   32'd0);
      check_eq("rst_ready", 32'(rdy[i]),  32'd0);
    end
    rst_n   = 1'b1;
    en      = 1'b0;
    s_valid = 1'b0;

    // Streaming: four samples, stop at phase 1 of the last data period.
    exp_hold();
    push_sample(14'h0001);
    push_sample(14'h1FFF);
    push_sample(14'h2000);
    push_sample(14'h3FFF);
    run_seq(17, -1, -1, -1);
    check_under(0);

    // Underflow: one sample, then two starved periods.
    exp_hold();
    push_sample(14'h0123);
    exp_under();
    exp_under();
    run_seq(13, -1, -1, -1);
    check_under(2);

    // Stop/restart: en drops at phase 1 and returns at phase 2 of the STOP period.
    exp_hold();
    push_sample(14'h0AAA);
    push_sample(14'h3555);
    push_sample(14'h0F0F);
    run_seq(13, 5, -1, -1);
    check_under(2);

    // Backpressure: six offered, four accepted while idle; refill while running.
    exp_hold();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_ready%0d", i), 32'(rdy[0]), 32'(i < 4));
      s_valid = 1'b1;
      s_data  = 14'h0100 + 14'(i);
      if (i < 4) exp_sample(s_data);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("bp_ready_full", 32'(rdy[0]), 32'd0);
    run_seq(25, -1, 7, 8);
    check_under(2);

    check_eq("q_hold_left", 32'(q0.size()), 32'd0);
    check_eq("q_mid_left",  32'(q1.size()), 32'd0);
    check_eq("q_ofs_left",  32'(q2.size()), 32'd0);
    for (int i = 0; i < 3; i++) check_eq($sformatf("extra_periods%0d", i), 32'(extra[i]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
